// File: rtl/laser_pkg.sv
// Types shared by the galvo point sequencer, display controller and point-RAM writer.
package laser_pkg;

    localparam int PT_DAC_W   = 16;
    localparam int PT_COLOR_W = 8;

    typedef struct packed {
        logic [PT_DAC_W-1:0]   x;
        logic [PT_DAC_W-1:0]   y;
        logic [PT_COLOR_W-1:0] r;
        logic [PT_COLOR_W-1:0] g;
        logic [PT_COLOR_W-1:0] b;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_DWELL = 3'd4,
        ST_GAP   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/dac_handoff.sv
// Single-axis valid/ready handoff: holds a word until the DAC sender takes it,
// then remembers that it was accepted until the next word is loaded.
module dac_handoff #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         accepted
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            valid    <= 1'b0;
            accepted <= 1'b0;
        end else if (load) begin
            data     <= data_in;
            valid    <= 1'b1;
            accepted <= 1'b0;
        end else if (valid && ready) begin
            valid    <= 1'b0;
            accepted <= 1'b1;
        end
    end

endmodule

// File: rtl/galvo_point_sequencer.sv
// Frame scheduler: walks the point RAM, hands x/y to the DAC senders, blanks
// while moving, lights each point for its dwell and inserts an inter-frame gap.
module galvo_point_sequencer
    import laser_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DAC_W   = 16,
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         enable_in,
    input  logic [ADDR_W-1:0]            frame_len_in,
    input  logic [CNT_W-1:0]             dwell_in,
    input  logic [CNT_W-1:0]             frame_delay_in,
    output logic [ADDR_W-1:0]            mem_addr_out,
    input  logic [2*DAC_W+3*COLOR_W-1:0] mem_data_in,
    output logic [DAC_W-1:0]             x_data_out,
    output logic                         x_valid_out,
    input  logic                         x_ready_in,
    output logic [DAC_W-1:0]             y_data_out,
    output logic                         y_valid_out,
    input  logic                         y_ready_in,
    output logic [3*COLOR_W-1:0]         rgb_out,
    output logic                         frame_sync_out,
    output logic                         busy_out
);

    localparam int PT_W = 2*DAC_W + 3*COLOR_W;

    seq_state_t           state;
    logic [ADDR_W-1:0]    index;
    logic [ADDR_W-1:0]    len_q;
    logic [CNT_W-1:0]     cnt;
    logic [3*COLOR_W-1:0] color_q;
    logic                 x_acc, y_acc;
    logic                 last_pt, restart, stop;

    assign busy_out = (state != ST_IDLE);
    assign last_pt  = (index == len_q - 1'b1);

    dac_handoff #(.W(DAC_W)) u_x_handoff (
        .clk      (clock_in),
        .rst_n    (reset_n_in),
        .load     (state == ST_LATCH),
        .data_in  (mem_data_in[PT_W-1 -: DAC_W]),
        .ready    (x_ready_in),
        .data     (x_data_out),
        .valid    (x_valid_out),
        .accepted (x_acc)
    );

    dac_handoff #(.W(DAC_W)) u_y_handoff (
        .clk      (clock_in),
        .rst_n    (reset_n_in),
        .load     (state == ST_LATCH),
        .data_in  (mem_data_in[PT_W-DAC_W-1 -: DAC_W]),
        .ready    (y_ready_in),
        .data     (y_data_out),
        .valid    (y_valid_out),
        .accepted (y_acc)
    );

    // restart = begin a frame at index 0 with a sync pulse; stop = back to IDLE.
    // A frame start that finds frame_len_in at 0 degrades to stop.
    always_comb begin
        restart = 1'b0;
        stop    = 1'b0;
        case (state)
            ST_IDLE:  restart = enable_in;
            ST_DWELL: if (cnt == '0) begin
                if (!enable_in)
                    stop = 1'b1;
                else if (last_pt && frame_delay_in == '0)
                    restart = 1'b1;
            end
            ST_GAP: begin
                if (!enable_in)
                    stop = 1'b1;
                else if (cnt == '0)
                    restart = 1'b1;
            end
            default: ;
        endcase
        if (restart && frame_len_in == '0) begin
            restart = 1'b0;
            stop    = 1'b1;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state          <= ST_IDLE;
            index          <= '0;
            len_q          <= '0;
            cnt            <= '0;
            color_q        <= '0;
            mem_addr_out   <= '0;
            rgb_out        <= '0;
            frame_sync_out <= 1'b0;
        end else begin
            frame_sync_out <= 1'b0;
            if (stop) begin
                state        <= ST_IDLE;
                index        <= '0;
                mem_addr_out <= '0;
                rgb_out      <= '0;
            end else if (restart) begin
                state          <= ST_FETCH;
                len_q          <= frame_len_in;
                index          <= '0;
                mem_addr_out   <= '0;
                rgb_out        <= '0;
                frame_sync_out <= 1'b1;
            end else begin
                case (state)
                    ST_FETCH: state <= ST_LATCH;
                    ST_LATCH: begin
                        color_q <= mem_data_in[3*COLOR_W-1:0];
                        state   <= ST_SEND;
                    end
                    ST_SEND: if (x_acc && y_acc) begin
                        cnt     <= dwell_in;
                        rgb_out <= color_q;
                        state   <= ST_DWELL;
                    end
                    ST_DWELL: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            rgb_out <= '0;
                            if (!last_pt) begin
                                index        <= index + 1'b1;
                                mem_addr_out <= index + 1'b1;
                                state        <= ST_FETCH;
                            end else begin
                                // zero delay is handled by restart, so the gap is at least one cycle
                                cnt   <= frame_delay_in - 1'b1;
                                state <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: cnt <= cnt - 1'b1;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_galvo_point_sequencer.sv
// Scoreboard bench: the driver pushes the expected point stream, a negedge
// monitor pops and compares on every handshake, lit run and frame sync.
module tb_galvo_point_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] frame_len;
    logic [15:0] dwell, delay;
    logic [11:0] mem_addr;
    logic [55:0] mem_data;
    logic [15:0] x_data, y_data;
    logic        x_valid, y_valid, x_ready, y_ready;
    logic [23:0] rgb;
    logic        frame_sync, busy;

    logic [55:0] ram [4096];

    logic [15:0] exp_x [$];
    logic [15:0] exp_y [$];
    logic [23:0] exp_col [$];
    int          exp_lit [$];
    int          sync_q [$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    galvo_point_sequencer dut (
        .clock_in       (clk),
        .reset_n_in     (rst_n),
        .enable_in      (enable),
        .frame_len_in   (frame_len),
        .dwell_in       (dwell),
        .frame_delay_in (delay),
        .mem_addr_out   (mem_addr),
        .mem_data_in    (mem_data),
        .x_data_out     (x_data),
        .x_valid_out    (x_valid),
        .x_ready_in     (x_ready),
        .y_data_out     (y_data),
        .y_valid_out    (y_valid),
        .y_ready_in     (y_ready),
        .rgb_out        (rgb),
        .frame_sync_out (frame_sync),
        .busy_out       (busy)
    );

    always @(posedge clk) mem_data <= ram[mem_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit          in_run = 1'b0;
    logic [23:0] run_col;
    int          run_len;
    logic        pxv = 1'b0, pxr = 1'b0, pyv = 1'b0, pyr = 1'b0;
    logic [15:0] pxd, pyd;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_run = 1'b0;
            pxv = 1'b0;
            pyv = 1'b0;
        end else begin
            if (pxv && !pxr) begin
                chk("x_hold_valid", x_valid, 1);
                chk("x_hold_data", x_data, pxd);
            end
            if (pyv && !pyr) begin
                chk("y_hold_valid", y_valid, 1);
                chk("y_hold_data", y_data, pyd);
            end
            if (x_valid || y_valid) chk("blank_while_moving", rgb, 0);
            if (x_valid && x_ready) begin
                if (exp_x.size() == 0) chk("x_unexpected", 1, 0);
                else chk("x_word", x_data, exp_x.pop_front());
            end
            if (y_valid && y_ready) begin
                if (exp_y.size() == 0) chk("y_unexpected", 1, 0);
                else chk("y_word", y_data, exp_y.pop_front());
            end
            if (rgb != '0) begin
                if (!in_run) begin
                    in_run = 1'b1;
                    run_col = rgb;
                    run_len = 0;
                end
                run_len++;
            end else if (in_run) begin
                in_run = 1'b0;
                if (exp_col.size() == 0) chk("rgb_unexpected", 1, 0);
                else begin
                    chk("rgb_colour", run_col, exp_col.pop_front());
                    chk("rgb_lit_cycles", run_len, exp_lit.pop_front());
                end
            end
            if (frame_sync) begin
                chk("sync_addr0", mem_addr, 0);
                sync_q.push_back(cyc);
            end
            pxv = x_valid; pxr = x_ready; pxd = x_data;
            pyv = y_valid; pyr = y_ready; pyd = y_data;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            x_ready = 1'($urandom_range(0, 1));
            y_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_point(input int i, input int dw);
        exp_x.push_back(ram[i][55:40]);
        exp_y.push_back(ram[i][39:24]);
        exp_col.push_back(ram[i][23:0]);
        exp_lit.push_back(dw + 1);
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_col.size() != 0 || exp_x.size() != 0 || exp_y.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < bound, 1);
        exp_x.delete(); exp_y.delete(); exp_col.delete(); exp_lit.delete();
    endtask

    // frames are stopped by dropping enable during the final gap (needs delay >= 2)
    task automatic run(input int len, input int dw, input int dl, input int fr, input int bound);
        sync_q.delete();
        for (int f = 0; f < fr; f++)
            for (int i = 0; i < len; i++) push_point(i, dw);
        frame_len = 12'(len); dwell = 16'(dw); delay = 16'(dl);
        enable = 1'b1;
        drain(bound);
        enable = 1'b0;
        tick();
        chk("idle_after_stop", busy, 0);
        chk("rgb_off_after_stop", rgb, 0);
        chk("sync_count", sync_q.size(), fr);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = {$urandom, $urandom} & 56'hFF_FFFF_FFFF_FFFF;
            ram[i][0] = 1'b1;
        end
        rst_n = 1'b0; enable = 1'b0; frame_len = '0; dwell = '0; delay = '0;
        x_ready = 1'b1; y_ready = 1'b1;
        repeat (3) tick();
        chk("rst_x_valid", x_valid, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync", frame_sync, 0);
        chk("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        tick();

        // basic cadence: 7 cycles per point, 4 gap cycles
        run(3, 2, 4, 2, 500);
        chk("sync_period", sync_q.size() >= 2 ? sync_q[1] - sync_q[0] : 0, 25);

        // X sender stalls while Y accepts at once
        begin
            int n = 0;
            sync_q.delete();
            push_point(0, 0);
            frame_len = 12'd1; dwell = '0; delay = 16'd2;
            x_ready = 1'b0; y_ready = 1'b1; enable = 1'b1;
            while (!x_valid && n < 50) begin tick(); n++; end
            chk("x_valid_seen", x_valid, 1);
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("stall_x_valid", x_valid, 1);
                chk("stall_x_data", x_data, ram[0][55:40]);
                chk("stall_y_dropped", y_valid, 0);
                chk("stall_rgb_blank", rgb, 0);
            end
            x_ready = 1'b1;
            drain(100);
            enable = 1'b0;
            tick();
            chk("stall_idle", busy, 0);
        end

        // zero-length frame never starts
        frame_len = '0; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("len0_busy", busy, 0);
            chk("len0_sync", frame_sync, 0);
            chk("len0_valid", x_valid | y_valid, 0);
        end
        enable = 1'b0;
        tick();

        // enable dropped mid-SEND: handshake finishes, point lights, then IDLE
        begin
            int n = 0;
            push_point(0, 1);
            frame_len = 12'd3; dwell = 16'd1; delay = 16'd2;
            x_ready = 1'b0; y_ready = 1'b1; enable = 1'b1;
            while (!x_valid && n < 50) begin tick(); n++; end
            chk("en_x_valid_seen", x_valid, 1);
            enable = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("en_hold_busy", busy, 1);
                chk("en_hold_x_valid", x_valid, 1);
            end
            x_ready = 1'b1;
            drain(100);
            chk("en_idle_busy", busy, 0);
            chk("en_idle_rgb", rgb, 0);
            chk("en_idle_valid", x_valid | y_valid, 0);
            tick();
        end

        // async reset mid-DWELL, then restart from address 0
        begin
            int n = 0;
            exp_x.push_back(ram[0][55:40]);
            exp_y.push_back(ram[0][39:24]);
            frame_len = 12'd3; dwell = 16'd5; delay = 16'd2; enable = 1'b1;
            while (rgb == '0 && n < 50) begin tick(); n++; end
            chk("rst_dwell_lit", rgb, ram[0][23:0]);
            tick(); tick();
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_rgb", rgb, 0);
            chk("arst_busy", busy, 0);
            chk("arst_valid", x_valid | y_valid, 0);
            chk("arst_sync", frame_sync, 0);
            chk("arst_addr", mem_addr, 0);
            chk("arst_xdata", x_data, 0);
            exp_x.delete(); exp_y.delete(); exp_col.delete(); exp_lit.delete();
            tick(); tick();
            enable = 1'b0;
            rst_n = 1'b1;
            tick();
            run(3, 0, 2, 1, 200);
        end

        // randomized frames with random sender back-pressure
        for (int r = 0; r < 5; r++) begin
            rand_ready = 1'b1;
            run($urandom_range(1, 8), $urandom_range(0, 3), $urandom_range(2, 5),
                $urandom_range(1, 3), 3000);
            rand_ready = 1'b0;
            x_ready = 1'b1; y_ready = 1'b1;
            tick();
        end

        // full-size frame: last point at 4094, index returns to 0
        run(4095, 0, 2, 2, 50000);
        chk("big_sync_period", sync_q.size() >= 2 ? sync_q[1] - sync_q[0] : 0, 4095 * 5 + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
